// File: rtl/ble_packet_serializer_pkg.sv
// ============================================================================
// ble_packet_serializer_pkg : shared constants and helpers for the BLE packet
// serializer.                                                  Rev 1.0
// ============================================================================
`default_nettype none

package ble_packet_serializer_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_ACCESS   = 3'd2;
  localparam logic [2:0] ST_PDU      = 3'd3;
  localparam logic [2:0] ST_CRC      = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [23:0] CRC_POLY           = 24'h00065B;
  localparam logic [23:0] CRC_PRESET_DEFAULT = 24'h555555;
  // Feedback from w[0] lands on w[2] after the right shift (x^4 tap).
  localparam logic [6:0]  WHITEN_TAP         = 7'b0000100;
  localparam logic [7:0]  PREAMBLE_AA        = 8'hAA;
  localparam logic [7:0]  PREAMBLE_55        = 8'h55;

  localparam int BIT_CNT_W = 8;
  localparam int LEN_W     = 9;

  function automatic logic [6:0] whiten_seed(input logic [5:0] ch);
    return {1'b1, ch[0], ch[1], ch[2], ch[3], ch[4], ch[5]};
  endfunction

  function automatic logic [6:0] whiten_step(input logic [6:0] w);
    return {w[0], w[6:1]} ^ (w[0] ? WHITEN_TAP : 7'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ble_crc24_lfsr.sv
// ============================================================================
// ble_crc24_lfsr : serial BLE CRC-24 engine with preset load, bit update and
// shift-out mode.                                              Rev 1.0
// ============================================================================
`default_nettype none

module ble_crc24_lfsr
  import ble_packet_serializer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] init,
  input  logic        enable,
  input  logic        din,
  input  logic        shift_out,
  output logic [23:0] crc
);

  logic feedback;
  assign feedback = crc[23] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 24'd0;
    end else if (load) begin
      crc <= init;
    end else if (enable) begin
      crc <= {crc[22:0], 1'b0} ^ (feedback ? CRC_POLY : 24'd0);
    end else if (shift_out) begin
      crc <= {crc[22:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ble_packet_serializer.sv
// ============================================================================
// ble_packet_serializer : turns one start edge into a whitened BLE link-layer
// packet bitstream (preamble, access address, PDU, CRC-24).    Rev 1.0
// ============================================================================
`default_nettype none

module ble_packet_serializer
  import ble_packet_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_PAYLOAD  = 37
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        txStart,
  input  logic [31:0] accessAddr,
  input  logic [5:0]  chanIdx,
  input  logic [23:0] crcInit,
  input  logic [7:0]  pduData,
  input  logic        pduValid,
  output logic        pduReady,
  output logic        txBit,
  output logic        txEn,
  output logic        bitStrobe,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LEN_W-1:0]     MAX_LEN  = LEN_W'(MAX_PAYLOAD);

  logic [2:0]           state;
  logic                 start_prev;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [4:0]           bit_idx;
  logic [LEN_W-1:0]     byte_idx;
  logic [LEN_W-1:0]     fetch_cnt;
  logic [LEN_W-1:0]     pdu_bytes;
  logic [31:0]          aa_reg;
  logic [7:0]           shift_byte;
  logic [7:0]           hold;
  logic                 hold_full;
  logic [6:0]           whit;
  logic                 err_r;

  logic [23:0]          crc_state;
  logic                 unused_crc_low;

  logic                 start_ok;
  logic                 wrap;
  logic                 on_air;
  logic                 last_pdu_byte;
  logic                 boundary;
  logic [LEN_W-1:0]     next_byte;
  logic                 abort;
  logic                 accept;
  logic                 pdu_bit;
  logic [7:0]           pre_byte;
  logic                 tx_bit;

  assign start_ok      = txStart && !start_prev && (state == ST_IDLE);
  assign wrap          = (bit_cnt == LAST_CNT);
  assign on_air        = (state == ST_PREAMBLE) || (state == ST_ACCESS) ||
                         (state == ST_PDU) || (state == ST_CRC);
  assign last_pdu_byte = ((byte_idx + 9'd1) == pdu_bytes);
  assign boundary      = wrap && (((state == ST_ACCESS) && (bit_idx == 5'd31)) ||
                         ((state == ST_PDU) && (bit_idx == 5'd7) && !last_pdu_byte));
  assign next_byte     = (state == ST_ACCESS) ? 9'd0 : (byte_idx + 9'd1);
  // Underrun, or header byte 1 carrying an oversize length, at the byte boundary.
  assign abort         = boundary && (!hold_full ||
                         ((next_byte == 9'd1) && ({1'b0, hold} > MAX_LEN)));

  // Ready is withheld on the boundary itself so nothing is taken during an abort.
  assign pduReady = !hold_full && ((state == ST_ACCESS) || (state == ST_PDU)) &&
                    (fetch_cnt < pdu_bytes) && !boundary;
  assign accept   = pduValid && pduReady;

  assign pdu_bit  = shift_byte[bit_idx[2:0]];
  assign pre_byte = aa_reg[0] ? PREAMBLE_55 : PREAMBLE_AA;

  ble_crc24_lfsr u_crc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_ok),
    .init      (crcInit),
    .enable    (wrap && (state == ST_PDU)),
    .din       (pdu_bit),
    .shift_out (wrap && (state == ST_CRC)),
    .crc       (crc_state)
  );

  assign unused_crc_low = ^crc_state[22:0];

  always_comb begin
    tx_bit = 1'b0;
    case (state)
      ST_PREAMBLE: tx_bit = pre_byte[bit_idx[2:0]];
      ST_ACCESS:   tx_bit = aa_reg[bit_idx];
      ST_PDU:      tx_bit = pdu_bit ^ whit[0];
      ST_CRC:      tx_bit = crc_state[23] ^ whit[0];
      default:     tx_bit = 1'b0;
    endcase
  end

  assign txBit     = tx_bit;
  assign txEn      = on_air;
  assign busy      = on_air;
  assign bitStrobe = on_air && (bit_cnt == '0);
  assign done      = (state == ST_DONE);
  assign err       = err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      start_prev <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= 5'd0;
      byte_idx   <= '0;
      fetch_cnt  <= '0;
      pdu_bytes  <= '0;
      aa_reg     <= 32'd0;
      shift_byte <= 8'd0;
      hold       <= 8'd0;
      hold_full  <= 1'b0;
      whit       <= 7'd0;
      err_r      <= 1'b0;
    end else begin
      start_prev <= txStart;

      if (accept) begin
        hold      <= pduData;
        hold_full <= 1'b1;
        fetch_cnt <= fetch_cnt + 9'd1;
        if (fetch_cnt == 9'd1) begin
          pdu_bytes <= {1'b0, pduData} + 9'd2;
        end
      end

      if (on_air) begin
        bit_cnt <= wrap ? '0 : (bit_cnt + 8'd1);
      end

      if (wrap && ((state == ST_PDU) || (state == ST_CRC))) begin
        whit <= whiten_step(whit);
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= ST_PREAMBLE;
            aa_reg    <= accessAddr;
            whit      <= whiten_seed(chanIdx);
            err_r     <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= 5'd0;
            byte_idx  <= '0;
            fetch_cnt <= '0;
            pdu_bytes <= 9'd2;
            hold_full <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (wrap) begin
            if (bit_idx == 5'd7) begin
              state   <= ST_ACCESS;
              bit_idx <= 5'd0;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        ST_ACCESS, ST_PDU: begin
          if (wrap) begin
            if (abort) begin
              state <= ST_DONE;
              err_r <= 1'b1;
            end else if (boundary) begin
              shift_byte <= hold;
              hold_full  <= 1'b0;
              byte_idx   <= next_byte;
              bit_idx    <= 5'd0;
              state      <= ST_PDU;
            end else if ((state == ST_PDU) && (bit_idx == 5'd7)) begin
              state   <= ST_CRC;
              bit_idx <= 5'd0;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        ST_CRC: begin
          if (wrap) begin
            if (bit_idx == 5'd23) begin
              state <= ST_DONE;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
